// File: rtl/iic_seq_pkg.sv
// ---------------------------------------------------------------------------
// iic_seq_pkg
// Shared definitions for the table-driven I2C init sequencer:
//   - table opcodes (2-bit op field at the top of each entry)
//   - sequencer state encoding
//   - entry field-slice helpers (entries are zero-extended to ENTRY_MAX_W
//     before being handed to the helpers, so one helper serves any width)
// ---------------------------------------------------------------------------
package iic_seq_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_RDCHK = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;

  // Widest entry the helpers accept ({op, addr, data}).
  localparam int ENTRY_MAX_W = 64;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_ISSUE      = 4'd2,
    S_WAIT_BUSY  = 4'd3,
    S_DLY        = 4'd4,
    S_NEXT       = 4'd5,
    S_DONE       = 4'd6,
    S_ERROR      = 4'd7,
    S_POLL_ISSUE = 4'd8,
    S_POLL_WAIT  = 4'd9
  } state_e;

  function automatic logic [1:0] entry_op(input logic [ENTRY_MAX_W-1:0] e,
                                          input int unsigned addr_w,
                                          input int unsigned data_w);
    return 2'(e >> (addr_w + data_w));
  endfunction

  // Caller truncates to its address width.
  function automatic logic [ENTRY_MAX_W-1:0] entry_addr(input logic [ENTRY_MAX_W-1:0] e,
                                                        input int unsigned data_w);
    return e >> data_w;
  endfunction

  // Data sits in the low bits; caller truncates to its data width.
  function automatic logic [ENTRY_MAX_W-1:0] entry_data(input logic [ENTRY_MAX_W-1:0] e);
    return e;
  endfunction

endpackage

// File: rtl/iic_seq_delay.sv
// ---------------------------------------------------------------------------
// iic_seq_delay
// Loadable down-counter with a done pulse. Used for table DELAY entries and
// for the status poll timer.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val (has priority over en)
//   load_val   : number of enabled cycles until done (0 behaves like 1)
//   en         : count while high
//   done       : high on the last enabled cycle of the interval
// With load_val = N >= 1, done is asserted on the N-th enabled cycle after the
// load; N = 0 gives done on the first enabled cycle.
// ---------------------------------------------------------------------------
module iic_seq_delay #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q > W'(1))) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign done = en & ~load & (cnt_q <= W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iic_seq_init.sv
// ---------------------------------------------------------------------------
// iic_seq_init
// Table-driven I2C register-initialisation sequencer. Walks an external
// synchronous command ROM and drives a byte-level IIC master through the
// trig/busy handshake. Opcodes: WRITE, RDCHK (read + compare with retry),
// DELAY (data x DELAY_UNIT cycles), END.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : pulse; reruns the table from entry 0 when in DONE/ERROR
//   tbl_idx      : ROM address; tbl_data is valid one clock later
//   tbl_data     : {op[1:0], addr, data}
//   device_id    : constant DEV_ID
//   iic_trig     : one-cycle request to the IIC master
//   w_r          : 1 = write, 0 = read
//   addr/data_in : register address / write data (RDCHK: expected value)
//   busy         : master busy; completion = falling edge after trig
//   data_out     : read data, valid when busy falls
//   byte_over    : master byte strobe, unused here
//   init_over    : sticky, table finished
//   init_err     : sticky, read-verify failed after MAX_RETRY attempts
//   err_idx      : table index of the failing entry
//   status       : last polled status value
//
// Build option: define INIT_STATUS_POLL_EN to keep reading POLL_ADDR every
// POLL_PERIOD cycles while in DONE; otherwise status is tied to 0 and the
// sequencer is silent after DONE.
// ---------------------------------------------------------------------------
module iic_seq_init
  import iic_seq_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                TBL_DEPTH   = 64,
  parameter logic [7:0]        DEV_ID      = 8'hB2,
  parameter int                DELAY_UNIT  = 1000,
  parameter int                DELAY_W     = 24,
  parameter int                MAX_RETRY   = 3,
  parameter logic [ADDR_W-1:0] POLL_ADDR   = 'h0502,
  parameter int                POLL_PERIOD = 1000000,
  localparam int               IDX_W       = $clog2(TBL_DEPTH),
  localparam int               ENTRY_W     = 2 + ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [IDX_W-1:0]   tbl_idx,
  input  logic [ENTRY_W-1:0] tbl_data,
  output logic [7:0]         device_id,
  output logic               iic_trig,
  output logic               w_r,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  data_in,
  input  logic               busy,
  input  logic [DATA_W-1:0]  data_out,
  input  logic               byte_over,
  output logic               init_over,
  output logic               init_err,
  output logic [IDX_W-1:0]   err_idx,
  output logic [DATA_W-1:0]  status
);

  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  // Entry decode straight off the ROM output (valid in DECODE).
  logic [ENTRY_MAX_W-1:0] tbl_ext;
  logic [1:0]             ent_op;
  logic [ADDR_W-1:0]      ent_addr;
  logic [DATA_W-1:0]      ent_data;
  logic [DELAY_W-1:0]     dly_prod;

  assign tbl_ext  = ENTRY_MAX_W'(tbl_data);
  assign ent_op   = entry_op(tbl_ext, ADDR_W, DATA_W);
  assign ent_addr = ADDR_W'(entry_addr(tbl_ext, DATA_W));
  assign ent_data = DATA_W'(entry_data(tbl_ext));
  assign dly_prod = DELAY_W'(ent_data) * DELAY_W'(DELAY_UNIT);

  state_e             state_q,     state_d;
  logic [IDX_W-1:0]   tbl_idx_q,   tbl_idx_d;
  logic               iic_trig_q,  iic_trig_d;
  logic               w_r_q,       w_r_d;
  logic [ADDR_W-1:0]  addr_q,      addr_d;
  logic [DATA_W-1:0]  data_in_q,   data_in_d;
  logic [1:0]         op_q,        op_d;
  logic [RETRY_W-1:0] retry_q,     retry_d;
  logic               seen_busy_q, seen_busy_d;
  logic               busy_q,      busy_d;
  logic               init_over_q, init_over_d;
  logic               init_err_q,  init_err_d;
  logic [IDX_W-1:0]   err_idx_q,   err_idx_d;

  logic busy_fall;
  logic done_ok;      // a transaction completed (busy seen high since trig)
  logic dly_load;
  logic dly_en;
  logic dly_done;

  assign busy_fall = ~busy & busy_q;
  assign done_ok   = busy_fall & seen_busy_q;

  iic_seq_delay #(.W(DELAY_W)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_prod),
    .en       (dly_en),
    .done     (dly_done)
  );

`ifdef INIT_STATUS_POLL_EN
  localparam int POLL_W = $clog2(POLL_PERIOD + 1);

  logic [DATA_W-1:0] status_q, status_d;
  logic              poll_done;
  logic              unused_in;

  // Timer is held loaded outside DONE so each stay in DONE starts a fresh period.
  iic_seq_delay #(.W(POLL_W)) u_poll (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q != S_DONE),
    .load_val (POLL_W'(POLL_PERIOD)),
    .en       (state_q == S_DONE),
    .done     (poll_done)
  );

  assign status    = status_q;
  assign unused_in = byte_over;
`else
  logic unused_in;
  assign status    = '0;
  assign unused_in = &{1'b0, byte_over, POLL_ADDR, POLL_PERIOD};
`endif

  always_comb begin
    state_d     = state_q;
    tbl_idx_d   = tbl_idx_q;
    iic_trig_d  = 1'b0;
    w_r_d       = w_r_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    op_d        = op_q;
    retry_d     = retry_q;
    seen_busy_d = seen_busy_q;
    busy_d      = busy;
    init_over_d = init_over_q;
    init_err_d  = init_err_q;
    err_idx_d   = err_idx_q;
    dly_load    = 1'b0;
    dly_en      = 1'b0;
`ifdef INIT_STATUS_POLL_EN
    status_d    = status_q;
`endif

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        op_d    = ent_op;
        retry_d = '0;
        case (ent_op)
          OP_WRITE, OP_RDCHK: begin
            addr_d    = ent_addr;
            data_in_d = ent_data;
            w_r_d     = (ent_op == OP_WRITE);
            state_d   = S_ISSUE;
          end
          OP_DELAY: begin
            dly_load = 1'b1;
            state_d  = S_DLY;
          end
          default: begin
            init_over_d = 1'b1;
            state_d     = S_DONE;
          end
        endcase
      end

      // Hold off the request while the master is still busy (e.g. a
      // transfer left running across a reset).
      S_ISSUE: begin
        if (!busy) begin
          iic_trig_d  = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (busy) begin
          seen_busy_d = 1'b1;
        end
        if (done_ok) begin
          if (op_q == OP_WRITE || data_out == data_in_q) begin
            retry_d = '0;
            state_d = S_NEXT;
          end else if (retry_q < RETRY_W'(MAX_RETRY - 1)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_ISSUE;
          end else begin
            err_idx_d  = tbl_idx_q;
            init_err_d = 1'b1;
            state_d    = S_ERROR;
          end
        end
      end

      S_DLY: begin
        dly_en = 1'b1;
        if (dly_done) begin
          state_d = S_NEXT;
        end
      end

      // Running off the end of the table acts as an implicit END.
      S_NEXT: begin
        if (tbl_idx_q == IDX_W'(TBL_DEPTH - 1)) begin
          init_over_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          tbl_idx_d = tbl_idx_q + IDX_W'(1);
          state_d   = S_FETCH;
        end
      end

      S_DONE, S_ERROR: begin
        if (start) begin
          init_over_d = 1'b0;
          init_err_d  = 1'b0;
          tbl_idx_d   = '0;
          state_d     = S_FETCH;
        end
`ifdef INIT_STATUS_POLL_EN
        else if (state_q == S_DONE && poll_done) begin
          addr_d  = POLL_ADDR;
          w_r_d   = 1'b0;
          state_d = S_POLL_ISSUE;
        end
`endif
      end

`ifdef INIT_STATUS_POLL_EN
      S_POLL_ISSUE: begin
        if (!busy) begin
          iic_trig_d  = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_POLL_WAIT;
        end
      end

      S_POLL_WAIT: begin
        if (busy) begin
          seen_busy_d = 1'b1;
        end
        if (done_ok) begin
          status_d = data_out;
          state_d  = S_DONE;
        end
      end
`endif

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      tbl_idx_q   <= '0;
      iic_trig_q  <= 1'b0;
      w_r_q       <= 1'b1;
      addr_q      <= '0;
      data_in_q   <= '0;
      op_q        <= OP_WRITE;
      retry_q     <= '0;
      seen_busy_q <= 1'b0;
      busy_q      <= 1'b0;
      init_over_q <= 1'b0;
      init_err_q  <= 1'b0;
      err_idx_q   <= '0;
`ifdef INIT_STATUS_POLL_EN
      status_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tbl_idx_q   <= tbl_idx_d;
      iic_trig_q  <= iic_trig_d;
      w_r_q       <= w_r_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      op_q        <= op_d;
      retry_q     <= retry_d;
      seen_busy_q <= seen_busy_d;
      busy_q      <= busy_d;
      init_over_q <= init_over_d;
      init_err_q  <= init_err_d;
      err_idx_q   <= err_idx_d;
`ifdef INIT_STATUS_POLL_EN
      status_q    <= status_d;
`endif
    end
  end

  assign tbl_idx   = tbl_idx_q;
  assign device_id = DEV_ID;
  assign iic_trig  = iic_trig_q;
  assign w_r       = w_r_q;
  assign addr      = addr_q;
  assign data_in   = data_in_q;
  assign init_over = init_over_q;
  assign init_err  = init_err_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_iic_seq_init.sv
// ---------------------------------------------------------------------------
// tb_iic_seq_init
// Directed tests for iic_seq_init with a small IIC master model. Stimulus
// pushes the expected transactions into a queue; the master model pops and
// compares on every iic_trig. Define INIT_STATUS_POLL_EN to cover polling.
// ---------------------------------------------------------------------------
module tb_iic_seq_init;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int TBL_DEPTH = 4;
  localparam int IDX_W     = 2;
  localparam int EW        = 2 + ADDR_W + DATA_W;

  localparam logic [1:0] OPW = 2'd0;
  localparam logic [1:0] OPR = 2'd1;
  localparam logic [1:0] OPD = 2'd2;
  localparam logic [1:0] OPE = 2'd3;

  typedef struct packed {
    logic              w_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              chk_data;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  tbl_idx;
  logic [EW-1:0]     tbl_data = '0;
  logic [7:0]        device_id;
  logic              iic_trig;
  logic              w_r;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              busy = 1'b0;
  logic [DATA_W-1:0] data_out = '0;
  logic              byte_over = 1'b0;
  logic              init_over;
  logic              init_err;
  logic [IDX_W-1:0]  err_idx;
  logic [DATA_W-1:0] status;

  iic_seq_init #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TBL_DEPTH   (TBL_DEPTH),
    .DEV_ID      (8'hB2),
    .DELAY_UNIT  (10),
    .DELAY_W     (24),
    .MAX_RETRY   (3),
    .POLL_ADDR   (16'h0502),
    .POLL_PERIOD (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tbl_idx   (tbl_idx),
    .tbl_data  (tbl_data),
    .device_id (device_id),
    .iic_trig  (iic_trig),
    .w_r       (w_r),
    .addr      (addr),
    .data_in   (data_in),
    .busy      (busy),
    .data_out  (data_out),
    .byte_over (byte_over),
    .init_over (init_over),
    .init_err  (init_err),
    .err_idx   (err_idx),
    .status    (status)
  );

  always #5 clk = ~clk;

  // Synchronous command ROM.
  logic [EW-1:0] rom [TBL_DEPTH];
  always @(posedge clk) tbl_data <= rom[tbl_idx];

  int   errors   = 0;
  int   checks   = 0;
  int   trig_cnt = 0;
  int   cyc      = 0;
  int   fall_cyc = 0;
  int   busy_len = 3;
  logic [DATA_W-1:0] rd_val = '0;
  txn_t exp_q[$];
  int   gap_q[$];   // negedges from previous busy fall to each trig

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
    return {op, a, d};
  endfunction

  function automatic txn_t tx(input logic w, input logic [15:0] a, input logic [7:0] d, input logic c);
    return '{w_r: w, addr: a, data: d, chk_data: c};
  endfunction

  // IIC master model and scoreboard monitor.
  initial begin : master
    txn_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (iic_trig) begin
        trig_cnt++;
        gap_q.push_back(cyc - fall_cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_trig: got trig w_r=%0b addr=0x%0h, required none", w_r, addr);
        end else begin
          e = exp_q.pop_front();
          check("txn_w_r", 32'(w_r), 32'(e.w_r));
          check("txn_addr", 32'(addr), 32'(e.addr));
          if (e.chk_data) check("txn_data", 32'(data_in), 32'(e.data));
        end
        busy = 1'b1;
        repeat (busy_len) begin
          @(negedge clk);
          cyc++;
        end
        data_out = rd_val;
        busy     = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_rom(input logic [EW-1:0] e0, e1, e2, e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  task automatic wait_end(input int max_cyc, input string name);
    int n = 0;
    while (!(init_over || init_err) && n < max_cyc) begin
      tick();
      n++;
    end
    if (!(init_over || init_err)) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, required init_over or init_err", name, n);
    end
  endtask

  task automatic wait_trigs(input int target, input int max_cyc, input string name);
    int n = 0;
    while (trig_cnt < target && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (trig_cnt < target) begin
      errors++;
      $display("FAIL %s: timeout, trigs=%0d required %0d", name, trig_cnt, target);
    end
  endtask

  function automatic int gap(input int i);
    return (gap_q.size() > i) ? gap_q[i] : -1;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int base;

    // Two writes then END; reset state checked while rst is held.
    load_rom(ent(OPW, 16'h0003, 8'h5A), ent(OPW, 16'h1281, 8'h04),
             ent(OPE, 16'h0000, 8'h00), ent(OPE, 16'h0000, 8'h00));
    exp_q.push_back(tx(1'b1, 16'h0003, 8'h5A, 1'b1));
    exp_q.push_back(tx(1'b1, 16'h1281, 8'h04, 1'b1));
    repeat (3) tick();
    check("rst_init_over", 32'(init_over), 0);
    check("rst_init_err", 32'(init_err), 0);
    check("rst_iic_trig", 32'(iic_trig), 0);
    check("rst_w_r", 32'(w_r), 1);
    check("rst_tbl_idx", 32'(tbl_idx), 0);
    check("rst_err_idx", 32'(err_idx), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_data_in", 32'(data_in), 0);
    check("rst_status", 32'(status), 0);
    check("device_id", 32'(device_id), 32'hB2);
    gap_q.delete();
    rst = 1'b0;
    wait_end(300, "wr_done");
    check("wr_over_latency", 32'(cyc - fall_cyc), 4);
    check("wr_init_over", 32'(init_over), 1);
    check("wr_init_err", 32'(init_err), 0);
    check("wr_end_idx", 32'(tbl_idx), 2);
    check("wr_trigs", 32'(trig_cnt), 2);
    check("wr_gap_back_to_back", 32'(gap(1)), 5);

    // RDCHK with matching read data.
    load_rom(ent(OPR, 16'h0003, 8'h5A), ent(OPE, 16'h0000, 8'h00),
             ent(OPE, 16'h0000, 8'h00), ent(OPE, 16'h0000, 8'h00));
    rd_val = 8'h5A;
    exp_q.push_back(tx(1'b0, 16'h0003, 8'h5A, 1'b1));
    base = trig_cnt;
    pulse_start();
    check("start_clears_over", 32'(init_over), 0);
    wait_end(300, "rdok_done");
    check("rdok_init_over", 32'(init_over), 1);
    check("rdok_init_err", 32'(init_err), 0);
    check("rdok_trigs", 32'(trig_cnt - base), 1);

    // RDCHK mismatch at entry 0: three attempts, then ERROR.
    rd_val = 8'h00;
    repeat (3) exp_q.push_back(tx(1'b0, 16'h0003, 8'h5A, 1'b1));
    base = trig_cnt;
    gap_q.delete();
    pulse_start();
    wait_end(400, "rdbad_done");
    check("rdbad_init_err", 32'(init_err), 1);
    check("rdbad_init_over", 32'(init_over), 0);
    check("rdbad_err_idx", 32'(err_idx), 0);
    check("rdbad_retry_gap", 32'(gap(1)), 2);
    repeat (20) tick();
    check("rdbad_trigs_held", 32'(trig_cnt - base), 3);
    check("rdbad_err_held", 32'(init_err), 1);

    // Mismatch at entry 1, restarted from ERROR.
    load_rom(ent(OPW, 16'h0010, 8'h77), ent(OPR, 16'h0003, 8'h5A),
             ent(OPE, 16'h0000, 8'h00), ent(OPE, 16'h0000, 8'h00));
    exp_q.push_back(tx(1'b1, 16'h0010, 8'h77, 1'b1));
    repeat (3) exp_q.push_back(tx(1'b0, 16'h0003, 8'h5A, 1'b1));
    base = trig_cnt;
    pulse_start();
    check("start_clears_err", 32'(init_err), 0);
    wait_end(400, "rdbad1_done");
    check("rdbad1_init_err", 32'(init_err), 1);
    check("rdbad1_err_idx", 32'(err_idx), 1);
    check("rdbad1_trigs", 32'(trig_cnt - base), 4);

    // DELAY 5 x 10 cycles between two writes.
    load_rom(ent(OPW, 16'h0001, 8'h01), ent(OPD, 16'h0000, 8'd5),
             ent(OPW, 16'h0002, 8'h02), ent(OPE, 16'h0000, 8'h00));
    exp_q.push_back(tx(1'b1, 16'h0001, 8'h01, 1'b1));
    exp_q.push_back(tx(1'b1, 16'h0002, 8'h02, 1'b1));
    gap_q.delete();
    pulse_start();
    wait_end(400, "dly5_done");
    check("dly5_gap", 32'(gap(1)), 58);
    check("dly5_init_over", 32'(init_over), 1);

    // DELAY 0: one cycle in the delay state.
    rom[1] = ent(OPD, 16'h0000, 8'd0);
    exp_q.push_back(tx(1'b1, 16'h0001, 8'h01, 1'b1));
    exp_q.push_back(tx(1'b1, 16'h0002, 8'h02, 1'b1));
    gap_q.delete();
    pulse_start();
    wait_end(400, "dly0_done");
    check("dly0_gap", 32'(gap(1)), 9);

    // No END entry: all four writes, then DONE without wrapping.
    load_rom(ent(OPW, 16'h000A, 8'hA0), ent(OPW, 16'h000B, 8'hB0),
             ent(OPW, 16'h000C, 8'hC0), ent(OPW, 16'h000D, 8'hD0));
    exp_q.push_back(tx(1'b1, 16'h000A, 8'hA0, 1'b1));
    exp_q.push_back(tx(1'b1, 16'h000B, 8'hB0, 1'b1));
    exp_q.push_back(tx(1'b1, 16'h000C, 8'hC0, 1'b1));
    exp_q.push_back(tx(1'b1, 16'h000D, 8'hD0, 1'b1));
    base = trig_cnt;
    pulse_start();
    wait_end(400, "noend_done");
    check("noend_trigs", 32'(trig_cnt - base), 4);
    check("noend_init_over", 32'(init_over), 1);
    repeat (10) tick();
    check("noend_idx_no_wrap", 32'(tbl_idx), 3);

    // Reset while the master is busy; the late busy fall must not advance.
    load_rom(ent(OPW, 16'h0100, 8'h11), ent(OPW, 16'h0200, 8'h22),
             ent(OPE, 16'h0000, 8'h00), ent(OPE, 16'h0000, 8'h00));
    busy_len = 8;
    exp_q.push_back(tx(1'b1, 16'h0100, 8'h11, 1'b1));
    exp_q.push_back(tx(1'b1, 16'h0100, 8'h11, 1'b1));
    exp_q.push_back(tx(1'b1, 16'h0200, 8'h22, 1'b1));
    base = trig_cnt;
    pulse_start();
    wait_trigs(base + 1, 50, "rstmid_first_trig");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rstmid_idx", 32'(tbl_idx), 0);
    check("rstmid_trig", 32'(iic_trig), 0);
    check("rstmid_w_r", 32'(w_r), 1);
    rst = 1'b0;
    wait_end(400, "rstmid_done");
    busy_len = 3;
    check("rstmid_trigs", 32'(trig_cnt - base), 3);
    check("rstmid_init_over", 32'(init_over), 1);

`ifdef INIT_STATUS_POLL_EN
    // Two status polls of 0x0502 while in DONE.
    rd_val = 8'h3C;
    exp_q.push_back(tx(1'b0, 16'h0502, 8'h00, 1'b0));
    exp_q.push_back(tx(1'b0, 16'h0502, 8'h00, 1'b0));
    base = trig_cnt;
    wait_trigs(base + 2, 400, "poll_two_reads");
    repeat (8) tick();
    check("poll_status", 32'(status), 32'h3C);
    check("poll_init_over", 32'(init_over), 1);
    rst = 1'b1;
    tick();
`else
    // Without polling the sequencer stays silent in DONE.
    base = trig_cnt;
    repeat (250) tick();
    check("nopoll_trigs", 32'(trig_cnt - base), 0);
    check("nopoll_status", 32'(status), 0);
    check("nopoll_init_over", 32'(init_over), 1);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iic_seq_init.md
Name: iic_seq_init

Overview:
- Generic, table-driven I2C register-initialisation sequencer.
- Drives the existing byte-level IIC master through the same trig/busy/byte_over handshake.
- Replaces hard-coded per-chip init FSMs (HDMI TX, codec, sensor) with an external command ROM.
- Supports write, read-verify with retry, timed delay and end-of-table opcodes, and reports a failing table index on error.

Parameters:
- ADDR_W, 16, register address width driven on addr.
- DATA_W, 8, register data width.
- TBL_DEPTH, 64, number of table entries; IDX_W = $clog2(TBL_DEPTH).
- DEV_ID, 8'hB2, 8-bit I2C device address driven on device_id.
- DELAY_UNIT, 1000, clk cycles per delay tick.
- DELAY_W, 24, width of the delay counter.
- MAX_RETRY, 3, read-verify attempts before error (minimum 1).
- POLL_ADDR, 16'h0502, status register read when INIT_STATUS_POLL_EN is defined.
- POLL_PERIOD, 1000000, cycles between status polls.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; restarts the sequence from entry 0 when in DONE or ERROR
- tbl_idx  out  IDX_W  table read address
- tbl_data  in  2+ADDR_W+DATA_W  entry {op[1:0], addr, data}; valid one clk after tbl_idx (sync ROM)
- device_id  out  8  constant DEV_ID
- iic_trig  out  1  one-cycle transaction request to the IIC master
- w_r  out  1  1 = write, 0 = read
- addr  out  ADDR_W  register address
- data_in  out  DATA_W  write data
- busy  in  1  IIC master busy
- data_out  in  DATA_W  read data; valid on busy falling edge
- byte_over  in  1  master byte strobe; ignored except for optional debug
- init_over  out  1  sticky high once the END entry completes
- init_err  out  1  sticky high on verify failure
- err_idx  out  IDX_W  table index of the failing entry
- status  out  DATA_W  last polled status value (0 if polling is compiled out)

Behaviour:
- Reset: all outputs 0 except w_r=1; state=FETCH, tbl_idx=0. The sequence starts automatically after reset deasserts.
- Reset asserted mid-transaction aborts immediately. The master is not notified; the sequencer ignores a late busy fall after reset.
- Opcodes: 0 WRITE, 1 RDCHK (read, compare against data), 2 DELAY (data×DELAY_UNIT cycles), 3 END.
- busy_fall = ~busy & busy_q. It counts as completion only in WAIT_BUSY and only after busy has been seen high since the trig.
- FETCH (1 cycle, ROM latency) -> DECODE:
  - WRITE / RDCHK -> ISSUE.
  - DELAY -> DLY.
  - END -> DONE.
- ISSUE (1 cycle): drive addr, data_in and w_r (WRITE=1, RDCHK=0), pulse iic_trig=1 -> WAIT_BUSY.
- WAIT_BUSY on qualified busy_fall:
  - WRITE -> NEXT.
  - RDCHK with data_out == entry data -> NEXT, retry count cleared.
  - RDCHK mismatch with retry < MAX_RETRY-1 -> retry+1, back to ISSUE (same entry).
  - RDCHK mismatch otherwise -> ERROR; err_idx=tbl_idx, init_err=1.
- DLY: counter counts up to data×DELAY_UNIT-1, then -> NEXT. data=0 gives exactly one cycle in DLY.
- NEXT: if tbl_idx == TBL_DEPTH-1 -> DONE (implicit END); otherwise tbl_idx+1 -> FETCH.
- DONE: init_over=1 (sticky until reset or start). start -> clears init_over/init_err, tbl_idx=0 -> FETCH.
- ERROR: holds; start behaves as in DONE.
- iic_trig is never asserted while busy=1. If busy is high on entry to ISSUE, the sequencer waits in ISSUE.
- Delay product is computed at DECODE into a DELAY_W register; overflow is the table author's responsibility.

Optional Feature:
- INIT_STATUS_POLL_EN defined:
  - In DONE, a POLL_PERIOD counter issues a read of POLL_ADDR (w_r=0).
  - On busy_fall, status=data_out.
  - init_over stays 1. start is honoured only between polls.
- Not defined: no transactions after DONE; status tied to 0.

Decomposition:
- Package iic_seq_pkg holds:
  - opcode localparams OP_WRITE/OP_RDCHK/OP_DELAY/OP_END;
  - the state encoding;
  - the entry field-slice helpers.
- One sub-module, iic_seq_delay: loadable down-counter with done pulse, reused for DLY and the poll timer.

Test Plan:
- Table {WRITE 0x0003/0x5A, WRITE 0x1281/0x04, END}: two trigs with w_r=1, addr/data as listed; init_over=1 one cycle after the END decode; init_err=0.
- RDCHK 0x0003 expect 0x5A, model returns 0x5A: single read (w_r=0), advance; model returns 0x00 three times (MAX_RETRY=3): exactly 3 trigs, init_err=1, err_idx=0.
- DELAY data=5, DELAY_UNIT=10: next trig exactly 50 cycles after DLY entry (±1 for FETCH); data=0: 1 cycle.
- Table with no END, TBL_DEPTH=4: four writes, then DONE; tbl_idx never wraps to 0.
- Reset pulse while busy=1 mid-write, then busy falls: no advance; sequence restarts at idx 0 after reset. start in DONE reruns the table.
- INIT_STATUS_POLL_EN, POLL_PERIOD=100: after DONE, reads of 0x0502 every ~100 cycles; status follows model value 0x3C.
